// File: rtl/uart_tx_8n1.sv
// Serial transmitter: start bit, 8 data bits LSB first, no parity, 1 or 2 stop bits.
// Takes bytes on a valid/ready handshake and drives them onto a line that idles high.
module uart_tx_8n1 #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] tx_data,
   input  logic       tx_valid,
   output logic       tx_ready,
   output logic       tx_out,
   output logic       tx_busy
);

   localparam int unsigned       BAUD_W    = $clog2(CLKS_PER_BIT);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
   localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_e;

   state_e            state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_idx_q, bit_idx_d;
   logic [7:0]        shift_q, shift_d;
   logic              tx_out_q, tx_out_d;
   logic              tx_busy_q, tx_busy_d;
   logic              accept;
   logic              bit_done;

   assign tx_ready = (state_q == IDLE) && ena && rst_n;
   assign accept   = tx_valid && tx_ready;
   assign bit_done = (baud_q == BAUD_LAST);

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every combinational output gets a default first, so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = START;
         START:   if (bit_done) state_d = DATA;
         DATA:    if (bit_done && (bit_idx_q == 3'd7)) state_d = STOP;
         STOP:    if (bit_done && (bit_idx_q == STOP_LAST)) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Bit index counts data bits in DATA and stop bits in STOP; it clears on any state change.
   always_comb begin
      baud_d    = baud_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      if (state_q == IDLE) begin
         baud_d    = '0;
         bit_idx_d = '0;
         if (accept) shift_d = tx_data;
      end else if (bit_done) begin
         baud_d    = '0;
         bit_idx_d = (state_d != state_q) ? 3'd0 : bit_idx_q + 3'd1;
         if (state_q == DATA) shift_d = {1'b0, shift_q[7:1]};
      end else begin
         baud_d = baud_q + BAUD_ONE;
      end
   end

   // Outputs are decoded from the next state so the line moves on the same edge as the FSM.
   always_comb begin
      tx_busy_d = (state_d != IDLE);
      case (state_d)
         START:   tx_out_d = 1'b0;
         DATA:    tx_out_d = shift_d[0];
         default: tx_out_d = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_q    <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
         tx_out_q  <= 1'b1;
         tx_busy_q <= 1'b0;
      end else begin
         baud_q    <= baud_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
         tx_out_q  <= tx_out_d;
         tx_busy_q <= tx_busy_d;
      end
   end

   assign tx_out  = tx_out_q;
   assign tx_busy = tx_busy_q;

endmodule

// File: tb/tb_uart_tx_8n1.sv
// Bench for uart_tx_8n1: two instances (4 clk/bit + 1 stop, 2 clk/bit + 2 stop) checked
// every cycle against a frame-position model, plus directed scenarios with literal expectations.
module tb_uart_tx_8n1;

   localparam int CA = 4;
   localparam int SA = 1;
   localparam int CB = 2;
   localparam int SB = 2;

   logic       clk;
   logic       rst_n;
   logic       ena_a, valid_a, ready_a, out_a, busy_a;
   logic [7:0] data_a;
   logic       ena_b, valid_b, ready_b, out_b, busy_b;
   logic [7:0] data_b;

   int total = 0;
   int bad   = 0;

   logic cap  [100];
   logic capb [100];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   uart_tx_8n1 #(.CLKS_PER_BIT(CA), .STOP_BITS(SA)) dut_a (
      .clk(clk), .rst_n(rst_n), .ena(ena_a), .tx_data(data_a), .tx_valid(valid_a),
      .tx_ready(ready_a), .tx_out(out_a), .tx_busy(busy_a));

   uart_tx_8n1 #(.CLKS_PER_BIT(CB), .STOP_BITS(SB)) dut_b (
      .clk(clk), .rst_n(rst_n), .ena(ena_b), .tx_data(data_b), .tx_valid(valid_b),
      .tx_ready(ready_b), .tx_out(out_b), .tx_busy(busy_b));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
      total++;
      if (act !== want) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
      end
   endtask

   // Line level k cycles into a frame: slot 0 is the start bit, slots 1..8 data, then stop.
   function automatic logic frame_level(input logic [7:0] b, input int c, input int k);
      int slot;
      slot = k / c;
      if (slot == 0) return 1'b0;
      if (slot <= 8) return b[slot-1];
      return 1'b1;
   endfunction

   // Model: a frame is either running (with a cycle position) or not.
   logic       m_act_a = 1'b0, m_act_b = 1'b0;
   int         m_k_a = 0, m_k_b = 0;
   logic [7:0] m_byte_a = '0, m_byte_b = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act_a <= 1'b0;
         m_k_a   <= 0;
      end else if (!m_act_a) begin
         if (ena_a && valid_a) begin
            m_act_a  <= 1'b1;
            m_k_a    <= 0;
            m_byte_a <= data_a;
         end
      end else if (m_k_a == (9 + SA) * CA - 1) begin
         m_act_a <= 1'b0;
      end else begin
         m_k_a <= m_k_a + 1;
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_act_b <= 1'b0;
         m_k_b   <= 0;
      end else if (!m_act_b) begin
         if (ena_b && valid_b) begin
            m_act_b  <= 1'b1;
            m_k_b    <= 0;
            m_byte_b <= data_b;
         end
      end else if (m_k_b == (9 + SB) * CB - 1) begin
         m_act_b <= 1'b0;
      end else begin
         m_k_b <= m_k_b + 1;
      end
   end

   always @(negedge clk) begin
      check("a_out",   out_a,   m_act_a ? frame_level(m_byte_a, CA, m_k_a) : 1'b1);
      check("a_busy",  busy_a,  m_act_a);
      check("a_ready", ready_a, !m_act_a && ena_a && rst_n);
      check("b_out",   out_b,   m_act_b ? frame_level(m_byte_b, CB, m_k_b) : 1'b1);
      check("b_busy",  busy_b,  m_act_b);
      check("b_ready", ready_b, !m_act_b && ena_b && rst_n);
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic wait_idle(input bit sel);
      int n;
      n = 0;
      while ((sel ? busy_b : busy_a) && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("idle_wait", sel ? busy_b : busy_a, 1'b0);
      step(1);
   endtask

   function automatic logic [7:0] decode_a(input int base, input int c);
      logic [7:0] v;
      for (int b = 0; b < 8; b++) v[b] = cap[base + (1 + b) * c + c / 2];
      return v;
   endfunction

   initial begin
      int         nb;
      int         r1, r2;
      logic       prev;
      int         lv [10];
      logic [7:0] got;
      lv = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

      rst_n = 1'b0;
      ena_a = 1'b0; valid_a = 1'b0; data_a = '0;
      ena_b = 1'b0; valid_b = 1'b0; data_b = '0;

      // Reset state, then reset in the middle of a frame.
      step(1);
      check("rst_out",   out_a,   1'b1);
      check("rst_busy",  busy_a,  1'b0);
      check("rst_ready", ready_a, 1'b0);
      step(1);
      rst_n = 1'b1;
      ena_a = 1'b1;
      #1 check("ready_after_rst", ready_a, 1'b1);
      step(1);
      data_a = 8'h55; valid_a = 1'b1;
      step(1);
      valid_a = 1'b0;
      step(10);
      check("pre_rst_busy", busy_a, 1'b1);
      #1 rst_n = 1'b0;
      #1;
      check("async_rst_out",   out_a,   1'b1);
      check("async_rst_busy",  busy_a,  1'b0);
      check("async_rst_ready", ready_a, 1'b0);
      step(2);
      rst_n = 1'b1;
      #1 check("ready_after_rel", ready_a, 1'b1);
      step(10);
      check("no_resume", busy_a, 1'b0);

      // Single byte 0xA5.
      data_a = 8'hA5; valid_a = 1'b1;
      step(1);
      valid_a = 1'b0;
      nb = 0;
      for (int i = 0; i < 45; i++) begin
         @(negedge clk);
         cap[i] = out_a;
         nb += int'(busy_a);
      end
      for (int b = 0; b < 10; b++)
         for (int j = 0; j < CA; j++)
            check("a5_level", cap[b * CA + j], lv[b][0]);
      for (int i = 40; i < 45; i++) check("a5_idle_after", cap[i], 1'b1);
      check("a5_busy_cycles", nb, 40);
      step(1);

      // Back-to-back 0x00 then 0xFF with valid held high.
      data_a = 8'h00; valid_a = 1'b1;
      r1 = -1; r2 = -1; prev = 1'b0;
      for (int n = 0; n < 100; n++) begin
         @(negedge clk);
         cap[n] = out_a;
         if (busy_a && !prev) begin
            if (r1 < 0) begin
               r1 = n;
               data_a = 8'hFF;
            end else if (r2 < 0) begin
               r2 = n;
               valid_a = 1'b0;
            end
         end
         prev = busy_a;
      end
      check("b2b_start_gap", r2 - r1, 41);
      if (r1 >= 0 && r2 > r1 && r2 + 40 <= 100) begin
         for (int b = 0; b < 10; b++) begin
            check("b2b_first_frame",  cap[r1 + b * CA + 2], (b == 9) ? 1'b1 : 1'b0);
            check("b2b_second_frame", cap[r2 + b * CA + 2], (b == 0) ? 1'b0 : 1'b1);
         end
      end
      check("b2b_no_third", busy_a, 1'b0);
      step(1);

      // ena low blocks acceptance; raising it starts the frame on the next edge.
      ena_a = 1'b0; data_a = 8'h5A; valid_a = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("ena0_out",   out_a,   1'b1);
         check("ena0_ready", ready_a, 1'b0);
      end
      @(posedge clk);
      #2 ena_a = 1'b1;
      @(negedge clk);
      check("ena1_ready", ready_a, 1'b1);
      @(negedge clk);
      check("ena1_start_out",  out_a,  1'b0);
      check("ena1_start_busy", busy_a, 1'b1);
      valid_a = 1'b0;
      wait_idle(1'b0);

      // 0xC3 frame; ena drops and data changes mid-frame.
      data_a = 8'hC3; valid_a = 1'b1;
      step(1);
      valid_a = 1'b0;
      nb = 0;
      fork
         for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            cap[i] = out_a;
            nb += int'(busy_a);
         end
         begin
            step(8);
            ena_a = 1'b0; data_a = 8'h3C; valid_a = 1'b1;
         end
      join
      got = decode_a(0, CA);
      check("c3_byte",  got, 8'hC3);
      check("c3_start", cap[CA / 2], 1'b0);
      check("c3_stop",  cap[9 * CA + CA / 2], 1'b1);
      check("c3_busy_cycles", nb, 40);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check("c3_no_second", busy_a, 1'b0);
      end
      valid_a = 1'b0;
      step(1);

      // Two stop bits, 2 clocks per bit, byte 0x81.
      ena_b = 1'b1; data_b = 8'h81; valid_b = 1'b1;
      step(1);
      valid_b = 1'b0;
      nb = 0;
      r1 = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         capb[i] = out_b;
         nb += int'(busy_b);
         if (busy_b && out_b && i >= 9 * CB) r1++;
      end
      for (int b = 0; b < 8; b++) got[b] = capb[(1 + b) * CB + CB / 2];
      check("s2_byte", got, 8'h81);
      check("s2_start", capb[0], 1'b0);
      check("s2_stop_cycles", r1, 4);
      check("s2_frame_cycles", nb, 22);
      check("s2_idle_after", capb[22], 1'b1);
      step(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
